dma_axi_req_issuer: RTL and testbench
=====================================

DMA_AXI_REQ_ISSUER -- requirements
Module: dma_axi_req_issuer

Interface
REQ-001 Parameter: STREAM_TYPE, default 0, 0 = read (drives AR), 1 = write (drives AW).
REQ-002 Parameter: MAX_OUTSTANDING, default 4, maximum address handshakes awaiting completion, legal range 1..15.
REQ-003 Port: clk  in  1  single clock, all logic rising-edge.
REQ-004 Port: rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 Port: dma_axi_req_i  in  s_dma_axi_req_t  request from streamer (valid, addr, alen, size, mode, strb).
REQ-006 Port: dma_axi_resp_o  out  s_dma_axi_resp_t  ready back to streamer.
REQ-007 Port: dma_abort_i  in  1  flush requests not yet presented on AXI.
REQ-008 Port: axi_addr_o / axi_len_o / axi_size_o / axi_burst_o  out  axi_addr_t / axi_alen_t / axi_size_t / axi_burst_t  AXI address channel payload.
REQ-009 Port: axi_valid_o  out  1 and axi_ready_i  in  1  AXI address handshake.
REQ-010 Port: wr_strb_o  out  axi_wr_strb_t  strobe of the burst last issued, for the write data path; 0 when STREAM_TYPE = 0.
REQ-011 Port: txn_done_i  in  1  one-cycle pulse on the final R beat (read) or B response (write).
REQ-012 Port: outstanding_o  out  4  current outstanding count; idle_o  out  1; err_o  out  1.

Function
REQ-013 Request acceptance SHALL occur in any cycle where dma_axi_req_i.valid && dma_axi_resp_o.ready, with the payload captured at that edge.
REQ-014 ready SHALL be 1 iff the buffer has a free entry and (outstanding + buffered + axi_valid_o) < MAX_OUTSTANDING.
REQ-015 Entries SHALL be issued in order, with axi_valid_o asserted no earlier than the cycle after acceptance (1-cycle minimum latency).
REQ-016 Once asserted, axi_valid_o and its payload SHALL stay stable until axi_ready_i (AXI rule), including during abort.
REQ-017 axi_burst_o SHALL be 2'b00 for DMA_MODE_FIXED and 2'b01 for DMA_MODE_INCR; addr/len/size SHALL pass through unchanged.
REQ-018 The outstanding counter SHALL +1 on the AXI handshake, -1 on txn_done_i, and stay unchanged when both occur in the same cycle.
REQ-019 txn_done_i with counter = 0 and no simultaneous handshake SHALL leave the counter at 0 and pulse err_o for one cycle.
REQ-020 FSM states: IDLE (nothing buffered, nothing valid), ISSUE (axi_valid_o high), WAIT (buffer empty, outstanding > 0).
REQ-021 Transitions: IDLE->ISSUE on accept; ISSUE->ISSUE on handshake with buffer non-empty; ISSUE->WAIT on handshake with buffer empty; WAIT->ISSUE on accept; WAIT->IDLE when the counter reaches 0.
REQ-022 idle_o SHALL be 1 only in IDLE.
REQ-023 dma_abort_i SHALL discard buffered entries not yet on AXI and force ready low while asserted; in-flight bursts SHALL still be counted down.
REQ-024 wr_strb_o SHALL update at each AXI handshake to the issued entry's strb.

Reset
REQ-025 While rst = 0: state IDLE, buffer empty, counter 0, axi_valid_o 0, all payload outputs 0, ready 0, err_o 0, idle_o 1.
REQ-026 Reset asserted mid-burst SHALL drop all state immediately, with no completion tracking retained after release.

Configuration
REQ-027 Macro DMA_REQ_BUF_EN: defined -> 2-entry FIFO between the streamer and AXI, so the streamer can have a request accepted while one is pending on AXI.
REQ-028 Macro DMA_REQ_BUF_EN: undefined -> single holding register, so ready is 0 whenever axi_valid_o is 1.

Structure
REQ-029 axi_burst_t encoding, the issuer state enum, and the MAX_OUTSTANDING default SHALL live in dma_utils_pkg; AXI types SHALL come from amba_axi_pkg.
REQ-030 The buffer SHALL be the sub-module dma_req_fifo, parameterised on depth (2 or 1), with its own full/empty flags.

Verification
REQ-031 Single request addr=0x1000, alen=15, mode INCR, axi_ready_i=1 -> axi_valid_o one cycle after accept, len=15, burst=01, outstanding_o=1; txn_done_i -> outstanding_o=0, idle_o=1.
REQ-032 MAX_OUTSTANDING=2, 3 back-to-back requests, no txn_done_i -> the third request is held off (ready=0) until one txn_done_i pulse, then issued.
REQ-033 axi_ready_i low for 5 cycles while abort pulses with a second request buffered -> the first request remains stable and issues; the second is never issued; outstanding_o=1.
REQ-034 Handshake and txn_done_i in the same cycle with count=1 -> count stays 1; txn_done_i at count 0 -> err_o is a 1-cycle pulse.
REQ-035 STREAM_TYPE=1, mode FIXED, strb=0x0C -> burst=00 and wr_strb_o=0x0C after the handshake.
REQ-036 rst driven low during WAIT with count=3 -> all outputs reach their reset values asynchronously; idle_o=1 after release.

Source files
------------

// File: rtl/amba_axi_pkg.sv
// AXI address-channel field types shared by the DMA issuer and its users.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package amba_axi_pkg;

    typedef logic [31:0] axi_addr_t;
    typedef logic [7:0]  axi_alen_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [7:0]  axi_wr_strb_t;

endpackage

// File: rtl/dma_utils_pkg.sv
// DMA issuer types: request/response structs, burst encoding, FSM states.
// Latency: n/a (types and a pure helper function).
// Backpressure: n/a (types only).
package dma_utils_pkg;

    import amba_axi_pkg::*;

    localparam int unsigned DMA_MAX_OUTSTANDING_DEF = 4;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;

    typedef enum logic {
        DMA_MODE_FIXED = 1'b0,
        DMA_MODE_INCR  = 1'b1
    } dma_mode_e;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_ISSUE = 2'd1,
        ISS_WAIT  = 2'd2
    } dma_issuer_state_e;

    // One buffered burst descriptor (request minus its valid bit).
    typedef struct packed {
        axi_addr_t    addr;
        axi_alen_t    alen;
        axi_size_t    size;
        dma_mode_e    mode;
        axi_wr_strb_t strb;
    } dma_req_entry_t;

    typedef struct packed {
        logic         valid;
        axi_addr_t    addr;
        axi_alen_t    alen;
        axi_size_t    size;
        dma_mode_e    mode;
        axi_wr_strb_t strb;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    function automatic axi_burst_t dma_mode_to_burst(input dma_mode_e mode);
        return (mode == DMA_MODE_FIXED) ? AXI_BURST_FIXED : AXI_BURST_INCR;
    endfunction

endpackage

// File: rtl/dma_axi_req_issuer_if.sv
// AXI address channel (AR or AW) bundle between the issuer and the fabric.
// Latency: n/a (wires only).
// Backpressure: valid/ready; master holds valid and payload until ready.
// Ports (master view): addr/len/size/burst/valid out, ready in.
interface dma_axi_req_issuer_if;

    import amba_axi_pkg::*;

    axi_addr_t  addr;
    axi_alen_t  len;
    axi_size_t  size;
    axi_burst_t burst;
    logic       valid;
    logic       ready;

    modport master (output addr, len, size, burst, valid, input  ready);
    modport slave  (input  addr, len, size, burst, valid, output ready);

endinterface

// File: rtl/dma_req_fifo.sv
// Small descriptor FIFO (depth 1 or 2) sitting between streamer and AXI stage.
// Latency: an entry pushed at an edge is visible on pop_dat_o the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush wins.
// Ports: clk, rst (async active-low), flush_i, push_i/push_dat_i,
//        pop_i/pop_dat_o, full_o, empty_o, count_o.
module dma_req_fifo
    import dma_utils_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           push_i,
    input  dma_req_entry_t push_dat_i,
    input  logic           pop_i,
    output dma_req_entry_t pop_dat_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [1:0]     count_o
);

    dma_req_entry_t mem_q [DEPTH];
    dma_req_entry_t mem_d [DEPTH];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           push_ok, pop_ok;

    // Pointers are one bit wide; with DEPTH = 1 they never leave 0.
    function automatic logic ptr_inc(input logic p);
        return (p == 1'(DEPTH - 1)) ? 1'b0 : ~p;
    endfunction

    assign full_o    = (cnt_q == 2'(DEPTH));
    assign empty_o   = (cnt_q == 2'd0);
    assign count_o   = cnt_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_axi_req_issuer.sv
// Issues streamer burst requests on an AXI AR/AW channel and tracks completions.
// Latency: axi valid rises the cycle after acceptance when the AXI stage is free.
// Backpressure: ready drops when buffer full, outstanding budget spent, or abort.
// Ports: clk, rst (async active-low); dma_axi_req_i / dma_axi_resp_o streamer
//        handshake; dma_abort_i; axi (address channel, master); wr_strb_o;
//        txn_done_i completion pulse; outstanding_o, idle_o, err_o status.
// Build option: DMA_REQ_BUF_EN adds a 2-entry buffer so a request can be
//        accepted while another waits on AXI; otherwise a single holding slot.
module dma_axi_req_issuer
    import amba_axi_pkg::*;
    import dma_utils_pkg::*;
#(
    parameter int unsigned STREAM_TYPE     = 0,
    parameter int unsigned MAX_OUTSTANDING = DMA_MAX_OUTSTANDING_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  s_dma_axi_req_t       dma_axi_req_i,
    output s_dma_axi_resp_t      dma_axi_resp_o,
    input  logic                 dma_abort_i,
    dma_axi_req_issuer_if.master axi,
    output axi_wr_strb_t         wr_strb_o,
    input  logic                 txn_done_i,
    output logic [3:0]           outstanding_o,
    output logic                 idle_o,
    output logic                 err_o
);

`ifdef DMA_REQ_BUF_EN
    localparam int unsigned BUF_DEPTH   = 2;
    localparam bit          HOLD_ON_VLD = 1'b0;
`else
    localparam int unsigned BUF_DEPTH   = 1;
    localparam bit          HOLD_ON_VLD = 1'b1;
`endif

    dma_issuer_state_e state_q, state_d;
    dma_req_entry_t    out_q, out_d;
    logic              valid_q, valid_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    axi_wr_strb_t      wstrb_q, wstrb_d;
    logic              rdy_en_q, rdy_en_d;

    dma_req_entry_t    req_ent, fifo_head;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [1:0]        fifo_cnt;
    logic [4:0]        inflight;
    logic              issue_rdy, accept, hs, out_free, load_fifo, bypass;

    dma_req_fifo #(.DEPTH(BUF_DEPTH)) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (dma_abort_i),
        .push_i     (fifo_push),
        .push_dat_i (req_ent),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    // Handshakes and the AXI output stage. Buffered entries always drain to
    // the output stage before a fresh request, so issue order is preserved;
    // a request arriving with the buffer empty and the stage free bypasses the
    // buffer to meet the one-cycle latency.
    always_comb begin
        req_ent   = '{addr: dma_axi_req_i.addr, alen: dma_axi_req_i.alen,
                      size: dma_axi_req_i.size, mode: dma_axi_req_i.mode,
                      strb: dma_axi_req_i.strb};
        inflight  = 5'(cnt_q) + 5'(fifo_cnt) + 5'(valid_q);
        // rdy_en_q keeps ready low while in reset without a combinational
        // path from the reset pin.
        issue_rdy = rdy_en_q && !dma_abort_i && !fifo_full
                    && (inflight < 5'(MAX_OUTSTANDING))
                    && !(HOLD_ON_VLD && valid_q);
        accept    = dma_axi_req_i.valid && issue_rdy;
        hs        = valid_q && axi.ready;
        out_free  = !valid_q || axi.ready;
        // Abort must not promote a buffered entry onto AXI.
        load_fifo = out_free && !fifo_empty && !dma_abort_i;
        bypass    = out_free && fifo_empty && accept;
        fifo_push = accept && !bypass;
        fifo_pop  = load_fifo;

        valid_d = valid_q;
        out_d   = out_q;
        if (load_fifo) begin
            valid_d = 1'b1;
            out_d   = fifo_head;
        end else if (bypass) begin
            valid_d = 1'b1;
            out_d   = req_ent;
        end else if (hs) begin
            valid_d = 1'b0;
        end

        wstrb_d = wstrb_q;
        if (hs && (STREAM_TYPE != 0)) begin
            wstrb_d = out_q.strb;
        end

        cnt_d = cnt_q;
        err_d = 1'b0;
        if (hs && !txn_done_i) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!hs && txn_done_i) begin
            if (cnt_q == 4'd0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        rdy_en_d = 1'b1;
    end

    // Next state follows the output stage and counter: ISSUE whenever a burst
    // is on AXI, WAIT while completions are pending, IDLE otherwise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ISS_IDLE: begin
                if (valid_d) state_d = ISS_ISSUE;
            end
            ISS_ISSUE: begin
                if (!valid_d) state_d = (cnt_d != 4'd0) ? ISS_WAIT : ISS_IDLE;
            end
            ISS_WAIT: begin
                if (valid_d)             state_d = ISS_ISSUE;
                else if (cnt_d == 4'd0)  state_d = ISS_IDLE;
            end
            default: state_d = ISS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ISS_IDLE;
            out_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            wstrb_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wstrb_q  <= wstrb_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    assign dma_axi_resp_o.ready = issue_rdy;
    assign axi.addr      = out_q.addr;
    assign axi.len       = out_q.alen;
    assign axi.size      = out_q.size;
    assign axi.burst     = dma_mode_to_burst(out_q.mode);
    assign axi.valid     = valid_q;
    assign wr_strb_o     = wstrb_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = (state_q == ISS_IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_dma_axi_req_issuer.sv
// Directed bench: read issuer (MAX_OUTSTANDING 4) and write issuer (MAX 2).
// Latency: n/a.
// Backpressure: axi ready driven directly by the directed steps.
module tb_dma_axi_req_issuer;

    import amba_axi_pkg::*;
    import dma_utils_pkg::*;

`ifdef DMA_REQ_BUF_EN
    localparam logic BUF = 1'b1;
`else
    localparam logic BUF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rst_b;
    s_dma_axi_req_t  req_a, req_b;
    s_dma_axi_resp_t resp_a, resp_b;
    logic            abort_a, abort_b, done_a, done_b;
    axi_wr_strb_t    wstrb_a, wstrb_b;
    logic [3:0]      outs_a, outs_b;
    logic            idle_a, idle_b, err_a, err_b;

    dma_axi_req_issuer_if a_if ();
    dma_axi_req_issuer_if b_if ();

    dma_axi_req_issuer #(.STREAM_TYPE(0), .MAX_OUTSTANDING(4)) u_rd (
        .clk(clk), .rst(rst_a), .dma_axi_req_i(req_a), .dma_axi_resp_o(resp_a),
        .dma_abort_i(abort_a), .axi(a_if.master), .wr_strb_o(wstrb_a),
        .txn_done_i(done_a), .outstanding_o(outs_a), .idle_o(idle_a), .err_o(err_a)
    );

    dma_axi_req_issuer #(.STREAM_TYPE(1), .MAX_OUTSTANDING(2)) u_wr (
        .clk(clk), .rst(rst_b), .dma_axi_req_i(req_b), .dma_axi_resp_o(resp_b),
        .dma_abort_i(abort_b), .axi(b_if.master), .wr_strb_o(wstrb_b),
        .txn_done_i(done_b), .outstanding_o(outs_b), .idle_o(idle_b), .err_o(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic s_dma_axi_req_t mk(input axi_addr_t a, input axi_alen_t l,
                                          input axi_size_t s, input dma_mode_e m,
                                          input axi_wr_strb_t st);
        mk = '{valid: 1'b1, addr: a, alen: l, size: s, mode: m, strb: st};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0;   req_b = '0;
        abort_a = 1'b0; abort_b = 1'b0;
        done_a = 1'b0;  done_b = 1'b0;
        a_if.ready = 1'b0; b_if.ready = 1'b0;

        // ---- reset values (asynchronous, before any clock edge) ----
        #2 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst ready_a", 32'(resp_a.ready), 32'd0);
        chk("rst valid_a", 32'(a_if.valid), 32'd0);
        chk("rst addr_a",  a_if.addr, 32'd0);
        chk("rst len_a",   32'(a_if.len), 32'd0);
        chk("rst burst_a", 32'(a_if.burst), 32'd0);
        chk("rst outs_a",  32'(outs_a), 32'd0);
        chk("rst idle_a",  32'(idle_a), 32'd1);
        chk("rst err_a",   32'(err_a), 32'd0);
        chk("rst wstrb_a", 32'(wstrb_a), 32'd0);
        chk("rst ready_b", 32'(resp_b.ready), 32'd0);
        chk("rst idle_b",  32'(idle_b), 32'd1);
        repeat (2) cyc();
        chk("rst ready_a clocked", 32'(resp_a.ready), 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        cyc();
        chk("post-rst ready_a", 32'(resp_a.ready), 32'd1);

        // ---- single INCR read burst, ready high ----
        a_if.ready = 1'b1;
        req_a = mk(32'h1000, 8'd15, 3'd3, DMA_MODE_INCR, 8'hFF);
        cyc();
        req_a = '0;
        #1;
        chk("s1 valid",    32'(a_if.valid), 32'd1);
        chk("s1 addr",     a_if.addr, 32'h1000);
        chk("s1 len",      32'(a_if.len), 32'd15);
        chk("s1 size",     32'(a_if.size), 32'd3);
        chk("s1 burst",    32'(a_if.burst), 32'd1);
        chk("s1 outs pre", 32'(outs_a), 32'd0);
        chk("s1 ready during valid", 32'(resp_a.ready), 32'(BUF));
        chk("s1 idle busy", 32'(idle_a), 32'd0);
        cyc();
        chk("s1 valid dropped", 32'(a_if.valid), 32'd0);
        chk("s1 outs",     32'(outs_a), 32'd1);
        chk("s1 wait idle", 32'(idle_a), 32'd0);
        chk("s1 rd wstrb", 32'(wstrb_a), 32'd0);
        done_a = 1'b1;
        cyc();
        done_a = 1'b0;
        #1;
        chk("s1 outs done", 32'(outs_a), 32'd0);
        chk("s1 idle done", 32'(idle_a), 32'd1);
        chk("s1 err",      32'(err_a), 32'd0);

        // ---- handshake + done in the same cycle; underflow error ----
        req_a = mk(32'h1100, 8'd0, 3'd2, DMA_MODE_INCR, 8'h00);
        cyc();
        req_a = '0;
        cyc();
        chk("s2 outs one", 32'(outs_a), 32'd1);
        req_a = mk(32'h1200, 8'd1, 3'd2, DMA_MODE_INCR, 8'h00);
        cyc();
        req_a = '0;
        done_a = 1'b1;
        #1;
        chk("s2 second valid", 32'(a_if.valid), 32'd1);
        cyc();
        done_a = 1'b0;
        chk("s2 hs+done outs", 32'(outs_a), 32'd1);
        chk("s2 hs+done err",  32'(err_a), 32'd0);
        done_a = 1'b1;
        cyc();
        done_a = 1'b0;
        chk("s2 outs zero", 32'(outs_a), 32'd0);
        chk("s2 no err",    32'(err_a), 32'd0);
        done_a = 1'b1;
        cyc();
        done_a = 1'b0;
        chk("s2 underflow err", 32'(err_a), 32'd1);
        chk("s2 underflow outs", 32'(outs_a), 32'd0);
        cyc();
        chk("s2 err one cycle", 32'(err_a), 32'd0);

        // ---- stalled AXI, second request, abort pulse ----
        a_if.ready = 1'b0;
        req_a = mk(32'h2000, 8'd3, 3'd3, DMA_MODE_INCR, 8'h00);
        cyc();
        req_a = mk(32'h3000, 8'd1, 3'd3, DMA_MODE_INCR, 8'h00);
        #1;
        chk("s3 second ready", 32'(resp_a.ready), 32'(BUF));
        cyc();
        req_a = '0;
        abort_a = 1'b1;
        #1;
        chk("s3 abort ready", 32'(resp_a.ready), 32'd0);
        chk("s3 abort valid", 32'(a_if.valid), 32'd1);
        chk("s3 abort addr",  a_if.addr, 32'h2000);
        cyc();
        abort_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s3 stall valid", 32'(a_if.valid), 32'd1);
            chk("s3 stall addr",  a_if.addr, 32'h2000);
            chk("s3 stall len",   32'(a_if.len), 32'd3);
            cyc();
        end
        a_if.ready = 1'b1;
        cyc();
        chk("s3 first issued", 32'(outs_a), 32'd1);
        chk("s3 no second",    32'(a_if.valid), 32'd0);
        repeat (3) begin
            cyc();
            chk("s3 second dropped", 32'(a_if.valid), 32'd0);
        end
        chk("s3 outs", 32'(outs_a), 32'd1);
        done_a = 1'b1;
        cyc();
        done_a = 1'b0;
        chk("s3 drained idle", 32'(idle_a), 32'd1);

        // ---- reset during WAIT with three outstanding ----
        for (int i = 0; i < 3; i++) begin
            req_a = mk(32'h5000 + 32'(i) * 32'h100, 8'd7, 3'd3, DMA_MODE_INCR, 8'h00);
            cyc();
            req_a = '0;
            cyc();
        end
        chk("s4 outs three", 32'(outs_a), 32'd3);
        chk("s4 wait idle",  32'(idle_a), 32'd0);
        #2 rst_a = 1'b0;
        #1;
        chk("s4 async outs",  32'(outs_a), 32'd0);
        chk("s4 async idle",  32'(idle_a), 32'd1);
        chk("s4 async valid", 32'(a_if.valid), 32'd0);
        chk("s4 async ready", 32'(resp_a.ready), 32'd0);
        chk("s4 async addr",  a_if.addr, 32'd0);
        chk("s4 async err",   32'(err_a), 32'd0);
        cyc();
        cyc();
        rst_a = 1'b1;
        cyc();
        cyc();
        chk("s4 release idle", 32'(idle_a), 32'd1);
        chk("s4 release outs", 32'(outs_a), 32'd0);
        done_a = 1'b1;
        cyc();
        done_a = 1'b0;
        chk("s4 no tracking err",  32'(err_a), 32'd1);
        chk("s4 no tracking outs", 32'(outs_a), 32'd0);

        // ---- write issuer: FIXED burst strobe, outstanding limit of 2 ----
        b_if.ready = 1'b1;
        req_b = mk(32'h4000, 8'd7, 3'd2, DMA_MODE_FIXED, 8'h0C);
        cyc();
        req_b = '0;
        #1;
        chk("s5 valid",      32'(b_if.valid), 32'd1);
        chk("s5 burst fixed", 32'(b_if.burst), 32'd0);
        chk("s5 addr",       b_if.addr, 32'h4000);
        chk("s5 len",        32'(b_if.len), 32'd7);
        chk("s5 strb pre",   32'(wstrb_b), 32'd0);
        cyc();
        chk("s5 strb",       32'(wstrb_b), 32'h0C);
        chk("s5 outs one",   32'(outs_b), 32'd1);
        chk("s5 ready one",  32'(resp_b.ready), 32'd1);
        req_b = mk(32'h4100, 8'd7, 3'd2, DMA_MODE_INCR, 8'hF0);
        cyc();
        req_b = '0;
        #1;
        chk("s5 valid2",     32'(b_if.valid), 32'd1);
        chk("s5 burst incr", 32'(b_if.burst), 32'd1);
        cyc();
        chk("s5 outs two",   32'(outs_b), 32'd2);
        chk("s5 strb2",      32'(wstrb_b), 32'hF0);
        chk("s5 ready limit", 32'(resp_b.ready), 32'd0);
        req_b = mk(32'h4200, 8'd3, 3'd2, DMA_MODE_FIXED, 8'h33);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s5 held ready", 32'(resp_b.ready), 32'd0);
            chk("s5 held valid", 32'(b_if.valid), 32'd0);
            cyc();
        end
        done_b = 1'b1;
        #1;
        chk("s5 ready before done", 32'(resp_b.ready), 32'd0);
        cyc();
        done_b = 1'b0;
        #1;
        chk("s5 outs after done", 32'(outs_b), 32'd1);
        chk("s5 ready after done", 32'(resp_b.ready), 32'd1);
        cyc();
        req_b = '0;
        #1;
        chk("s5 third valid", 32'(b_if.valid), 32'd1);
        chk("s5 third addr",  b_if.addr, 32'h4200);
        chk("s5 third burst", 32'(b_if.burst), 32'd0);
        cyc();
        chk("s5 third outs",  32'(outs_b), 32'd2);
        chk("s5 third strb",  32'(wstrb_b), 32'h33);
        chk("s5 err_b",       32'(err_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
